// File: rtl/ccff_loader_pkg.sv
// Shared definitions for the configuration-chain loader: register map,
// control/status bit positions and the shift FSM state encoding.
package ccff_loader_pkg;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_LEN    = 2'd1;
   localparam logic [1:0] REG_DATA   = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   localparam int CTRL_START      = 0;
   localparam int CTRL_PROG_RESET = 1;
   localparam int CTRL_ABORT      = 2;

   localparam int STAT_BUSY      = 0;
   localparam int STAT_DONE      = 1;
   localparam int STAT_EMPTY     = 2;
   localparam int STAT_FULL      = 3;
   localparam int STAT_STARVED   = 4;
   localparam int STAT_LEVEL_LSB = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT_LO,
      ST_SHIFT_HI,
      ST_DONE
   } state_t;

endpackage

// File: rtl/ccff_word_fifo.sv
// Synchronous 32-bit word FIFO with flush; a pop and a push in the same
// cycle are both honoured, even when full.
module ccff_word_fifo #(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic        pop,
   input  logic        flush,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        full,
   output logic        empty,
   output logic [7:0]  level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [7:0] DEPTH_L = 8'(DEPTH);

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (level == DEPTH_L);
   assign empty   = (level == 8'd0);
   assign rdata   = mem[rd_ptr];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= 8'd0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 8'd1;
            2'b01:   level <= level - 8'd1;
            default: level <= level;
         endcase
      end
   end

   // NOTE: the storage array is deliberately not reset; pointers and level define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/ccff_loader.sv
// Wishbone-programmable loader: queues bitstream words and shifts them
// MSB-first onto ccff_head with a divided, registered prog_clk.
module ccff_loader
   import ccff_loader_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        prog_clk_o,
   output logic        prog_reset_o,
   output logic        ccff_head_o,
   input  logic        ccff_tail_i,
   output logic        busy_o
);

   localparam int HALF = CLK_DIV / 2;
   localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [DW-1:0] HALF_LAST = DW'(HALF - 1);

   logic [1:0]    reg_sel;
   logic          wb_req, wb_accept, wr_en;
   logic          start_pend, abort_cmd, done_clr, starved_clr;
   logic [31:0]   len_q, readback, rd_mux;
   logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [31:0]   fifo_rdata;
   logic [7:0]    fifo_level;
   state_t        state;
   logic [DW-1:0] div_cnt;
   logic [31:0]   shreg, remaining;
   logic [4:0]    bit_idx;
   logic          done_q, starved_q;
   logic          unused_ok;

   assign unused_ok = ^{wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0]};

   ccff_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (wb_clk_i),
      .rst   (wb_rst_i),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .flush (abort_cmd),
      .wdata (wbs_dat_i),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      reg_sel     = wbs_adr_i[3:2];
      fifo_pop    = (state == ST_LOAD) && !fifo_empty;
      wb_req      = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
      // A DATA write into a full FIFO stalls unless a pop frees a slot this cycle.
      wb_accept   = wb_req & ~(wbs_we_i & (reg_sel == REG_DATA) & fifo_full & ~fifo_pop);
      wr_en       = wb_accept & wbs_we_i;
      fifo_push   = wr_en && (reg_sel == REG_DATA);
      abort_cmd   = wr_en && (reg_sel == REG_CTRL) && wbs_dat_i[CTRL_ABORT];
      done_clr    = wr_en && (reg_sel == REG_STATUS) && wbs_dat_i[STAT_DONE];
      starved_clr = wr_en && (reg_sel == REG_STATUS) && wbs_dat_i[STAT_STARVED];
      rd_mux      = 32'd0;
      case (reg_sel)
         REG_CTRL:   rd_mux[CTRL_PROG_RESET] = prog_reset_o;
         REG_LEN:    rd_mux = len_q;
         REG_DATA:   rd_mux = readback;
         default: begin
            rd_mux[STAT_BUSY]    = busy_o;
            rd_mux[STAT_DONE]    = done_q;
            rd_mux[STAT_EMPTY]   = fifo_empty;
            rd_mux[STAT_FULL]    = fifo_full;
            rd_mux[STAT_STARVED] = starved_q;
            rd_mux[STAT_LEVEL_LSB +: 8] = fifo_level;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wbs_ack_o    <= 1'b0;
         wbs_dat_o    <= 32'd0;
         len_q        <= 32'd0;
         prog_reset_o <= 1'b1;
         start_pend   <= 1'b0;
      end else begin
         wbs_ack_o  <= wb_accept;
         wbs_dat_o  <= (wb_accept && !wbs_we_i) ? rd_mux : 32'd0;
         start_pend <= wr_en && (reg_sel == REG_CTRL) && wbs_dat_i[CTRL_START]
                       && !wbs_dat_i[CTRL_ABORT] && !busy_o;
         if (wr_en && reg_sel == REG_CTRL) prog_reset_o <= wbs_dat_i[CTRL_PROG_RESET];
         if (wr_en && reg_sel == REG_LEN && !busy_o) len_q <= wbs_dat_i;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state       <= ST_IDLE;
         div_cnt     <= '0;
         shreg       <= 32'd0;
         remaining   <= 32'd0;
         bit_idx     <= 5'd0;
         prog_clk_o  <= 1'b0;
         ccff_head_o <= 1'b0;
         busy_o      <= 1'b0;
         done_q      <= 1'b0;
         starved_q   <= 1'b0;
         readback    <= 32'd0;
      end else begin
         if (done_clr)    done_q    <= 1'b0;
         if (starved_clr) starved_q <= 1'b0;
         if (abort_cmd) begin
            state      <= ST_IDLE;
            div_cnt    <= '0;
            prog_clk_o <= 1'b0;
            busy_o     <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start_pend) begin
                     busy_o    <= 1'b1;
                     remaining <= len_q;
                     if (len_q == 32'd0) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                     end else begin
                        state <= ST_LOAD;
                     end
                  end
               end
               ST_LOAD: begin
                  if (!fifo_empty) begin
                     shreg       <= fifo_rdata;
                     ccff_head_o <= fifo_rdata[31];
                     bit_idx     <= 5'd31;
                     div_cnt     <= '0;
                     state       <= ST_SHIFT_LO;
                  end else begin
                     starved_q <= 1'b1;
                  end
               end
               ST_SHIFT_LO: begin
                  if (div_cnt == HALF_LAST) begin
                     div_cnt    <= '0;
                     prog_clk_o <= 1'b1;
                     state      <= ST_SHIFT_HI;
                  end else begin
                     div_cnt <= div_cnt + 1'b1;
                  end
               end
               ST_SHIFT_HI: begin
                  if (div_cnt == '0) readback <= {readback[30:0], ccff_tail_i};
                  if (div_cnt == HALF_LAST) begin
                     div_cnt    <= '0;
                     prog_clk_o <= 1'b0;
                     remaining  <= remaining - 32'd1;
                     // A partial final word ends here mid-word; its low bits are never shifted.
                     if (remaining == 32'd1) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                     end else if (bit_idx == 5'd0) begin
                        state <= ST_LOAD;
                     end else begin
                        shreg       <= {shreg[30:0], 1'b0};
                        ccff_head_o <= shreg[30];
                        bit_idx     <= bit_idx - 5'd1;
                        state       <= ST_SHIFT_LO;
                     end
                  end else begin
                     div_cnt <= div_cnt + 1'b1;
                  end
               end
               ST_DONE: begin
                  state  <= ST_IDLE;
                  busy_o <= 1'b0;
               end
               default: begin
                  state  <= ST_IDLE;
                  busy_o <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader: bus tasks drive the register map while a
// prog_clk monitor pops expected ccff_head bits from a scoreboard queue.
module tb_ccff_loader;

   localparam int CLK_DIV    = 4;
   localparam int FIFO_DEPTH = 4;
   localparam int HALF       = CLK_DIV / 2;

   localparam logic [31:0] A_CTRL = 32'h0;
   localparam logic [31:0] A_LEN  = 32'h4;
   localparam logic [31:0] A_DATA = 32'h8;
   localparam logic [31:0] A_STAT = 32'hC;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stb = 1'b0;
   logic        cyc = 1'b0;
   logic        we  = 1'b0;
   logic [3:0]  sel = 4'hF;
   logic [31:0] adr = 32'd0;
   logic [31:0] dat_w = 32'd0;
   logic        ack;
   logic [31:0] dat_r;
   logic        prog_clk, prog_reset, head, tail, busy;
   logic        loop_en = 1'b0;

   assign tail = loop_en & head;

   always #5 clk = ~clk;

   ccff_loader #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .wb_clk_i     (clk),
      .wb_rst_i     (rst),
      .wbs_stb_i    (stb),
      .wbs_cyc_i    (cyc),
      .wbs_we_i     (we),
      .wbs_sel_i    (sel),
      .wbs_adr_i    (adr),
      .wbs_dat_i    (dat_w),
      .wbs_ack_o    (ack),
      .wbs_dat_o    (dat_r),
      .prog_clk_o   (prog_clk),
      .prog_reset_o (prog_reset),
      .ccff_head_o  (head),
      .ccff_tail_i  (tail),
      .busy_o       (busy)
   );

   int   num_checks = 0;
   int   num_errors = 0;
   bit   exp_q[$];
   int   pulse_cnt = 0;
   int   high_cnt  = 0;
   bit   chk_width = 1'b1;
   logic prev_pclk = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      num_checks++;
      assert (obs === exp) else begin
         num_errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Scoreboard consumer: each prog_clk rising edge must carry the next expected bit.
   always @(negedge clk) begin
      if (!rst) begin
         if (prog_clk === 1'b1 && prev_pclk === 1'b0) begin
            pulse_cnt++;
            if (exp_q.size() > 0) check("head_bit", 32'(head), 32'(exp_q.pop_front()));
            else check("sb_nonempty", 32'(exp_q.size()), 32'd1);
         end
         if (prog_clk === 1'b1) begin
            high_cnt++;
         end else begin
            if (prev_pclk === 1'b1 && chk_width) check("pclk_high_cycles", 32'(high_cnt), 32'(HALF));
            high_cnt = 0;
         end
         prev_pclk = prog_clk;
      end
   end

   task automatic wb_cycle(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                           output logic [31:0] rdata);
      int n = 0;
      @(posedge clk); #1;
      stb = 1'b1; cyc = 1'b1; we = wr; adr = addr; dat_w = wdata;
      do begin
         @(posedge clk); #1;
         n++;
      end while (ack !== 1'b1 && n < 200);
      if (ack !== 1'b1) check("wb_ack_timeout", 32'(ack), 32'd1);
      rdata = dat_r;
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
   endtask

   task automatic wb_write(input logic [31:0] addr, input logic [31:0] wdata);
      logic [31:0] dummy;
      wb_cycle(addr, 1'b1, wdata, dummy);
   endtask

   task automatic wb_read(input logic [31:0] addr, output logic [31:0] rdata);
      wb_cycle(addr, 1'b0, 32'd0, rdata);
   endtask

   task automatic push_bits(input logic [31:0] word, input int nbits);
      for (int i = 31; i >= 32 - nbits; i--) exp_q.push_back(word[i]);
   endtask

   task automatic wait_done();
      logic [31:0] s;
      int n = 0;
      do begin
         wb_read(A_STAT, s);
         n++;
      end while (!s[1] && n < 1000);
      check("done_seen", 32'(s[1]), 32'd1);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] words [5];
      int base, n, cnt;

      words[0] = 32'hDEAD_BEEF;
      words[1] = 32'h0F0F_1234;
      words[2] = 32'h8000_0001;
      words[3] = 32'h5555_AAAA;
      words[4] = 32'hC3A5_961E;

      // Reset state
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_prog_reset", 32'(prog_reset), 32'd1);
      check("rst_prog_clk", 32'(prog_clk), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_head", 32'(head), 32'd0);
      check("rst_ack", 32'(ack), 32'd0);
      wb_read(A_STAT, rd);
      check("rst_status", rd, 32'h0000_0004);
      wb_read(A_LEN, rd);
      check("rst_len", rd, 32'd0);
      wb_read(A_DATA, rd);
      check("rst_readback", rd, 32'd0);

      // Partial final word: 8 bits of 0xA5000000
      wb_write(A_LEN, 32'd8);
      push_bits(32'hA500_0000, 8);
      wb_write(A_DATA, 32'hA500_0000);
      base = pulse_cnt;
      wb_write(A_CTRL, 32'h1);
      n = 0;
      while (prog_clk !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("start_latency", 32'(n), 32'(2 + HALF));
      check("prog_reset_cleared", 32'(prog_reset), 32'd0);
      wait_done();
      check("partial_pulses", 32'(pulse_cnt - base), 32'd8);
      wb_read(A_STAT, rd);
      check("partial_status", rd, 32'h0000_0006);
      check("partial_sb_drained", 32'(exp_q.size()), 32'd0);
      wb_write(A_STAT, 32'h2);
      wb_read(A_STAT, rd);
      check("done_w1c", rd, 32'h0000_0004);

      // Loopback: readback equals shifted word
      loop_en = 1'b1;
      wb_write(A_LEN, 32'd32);
      push_bits(32'h1234_5678, 32);
      wb_write(A_DATA, 32'h1234_5678);
      wb_write(A_CTRL, 32'h1);
      wait_done();
      wb_read(A_DATA, rd);
      check("loopback_readback", rd, 32'h1234_5678);
      loop_en = 1'b0;
      wb_write(A_STAT, 32'h2);

      // Back-pressure: fifth write into a 4-deep FIFO stalls until a pop
      wb_write(A_LEN, 32'd160);
      for (int i = 0; i < 5; i++) push_bits(words[i], 32);
      for (int i = 0; i < 4; i++) wb_write(A_DATA, words[i]);
      wb_read(A_STAT, rd);
      check("bp_full_status", rd, 32'h0000_0408);
      @(posedge clk); #1;
      stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = A_DATA; dat_w = words[4];
      cnt = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (ack === 1'b1) cnt++;
      end
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      check("bp_ack_withheld", 32'(cnt), 32'd0);
      base = pulse_cnt;
      wb_write(A_CTRL, 32'h1);
      wb_write(A_DATA, words[4]);
      wb_read(A_STAT, rd);
      check("bp_status_after_pop", rd, 32'h0000_0409);
      check("bp_level", 32'(rd[15:8]), 32'd4);
      wait_done();
      check("bp_pulses", 32'(pulse_cnt - base), 32'd160);
      wb_read(A_STAT, rd);
      check("bp_final_status", rd, 32'h0000_0006);
      check("bp_sb_drained", 32'(exp_q.size()), 32'd0);
      wb_write(A_STAT, 32'h2);

      // Starve and resume
      wb_write(A_LEN, 32'd64);
      push_bits(words[1], 32);
      wb_write(A_DATA, words[1]);
      base = pulse_cnt;
      wb_write(A_CTRL, 32'h1);
      n = 0;
      while (!((pulse_cnt - base) == 32 && prog_clk === 1'b0) && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      check("starve_reached_32", 32'(pulse_cnt - base), 32'd32);
      cnt = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (prog_clk !== 1'b0) cnt++;
      end
      check("starve_pclk_low", 32'(cnt), 32'd0);
      wb_read(A_STAT, rd);
      check("starve_status", rd, 32'h0000_0015);
      push_bits(words[3], 32);
      wb_write(A_DATA, words[3]);
      wait_done();
      check("starve_pulses", 32'(pulse_cnt - base), 32'd64);
      wb_read(A_STAT, rd);
      check("starve_final_status", rd, 32'h0000_0016);
      wb_write(A_STAT, 32'h12);
      wb_read(A_STAT, rd);
      check("sticky_w1c", rd, 32'h0000_0004);

      // Abort mid-word flushes FIFO without setting done
      chk_width = 1'b0;
      wb_write(A_LEN, 32'd32);
      push_bits(words[0], 32);
      wb_write(A_DATA, words[0]);
      wb_write(A_DATA, words[2]);
      base = pulse_cnt;
      wb_write(A_CTRL, 32'h1);
      n = 0;
      while ((pulse_cnt - base) < 10 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      wb_write(A_CTRL, 32'h4);
      check("abort_pclk_low", 32'(prog_clk), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      exp_q.delete();
      base = pulse_cnt;
      wait_cycles(10);
      check("abort_no_pulses", 32'(pulse_cnt - base), 32'd0);
      wb_read(A_STAT, rd);
      check("abort_status", rd, 32'h0000_0004);

      // Abort wins over a simultaneous start
      wb_write(A_CTRL, 32'h5);
      wait_cycles(6);
      check("abort_beats_start", 32'(busy), 32'd0);

      // Start with LEN=0 only sets done
      wb_write(A_LEN, 32'd0);
      base = pulse_cnt;
      wb_write(A_CTRL, 32'h1);
      wait_cycles(4);
      wb_read(A_STAT, rd);
      check("len0_status", rd, 32'h0000_0006);
      check("len0_no_pulses", 32'(pulse_cnt - base), 32'd0);
      chk_width = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule

// File: doc/ccff_loader.md
# ccff_loader

Wishbone-programmable configuration-chain loader for the FPGA fabric in the Caravel user area. Firmware pushes bitstream words over the management Wishbone bus. The block serialises them MSB-first onto `ccff_head` and generates a registered, divided `prog_clk`. It drives `prog_reset` from a control bit and captures `ccff_tail` into a readback register, so the fabric can be configured and verified without external GPIO drivers.

## Interface
- `CLK_DIV`, default 4: `wb_clk_i` cycles per `prog_clk` period; even, ≥2.
- `FIFO_DEPTH`, default 8: bitstream word FIFO depth; power of two, ≤128.
- `wb_clk_i`  in  1  sole clock.
- `wb_rst_i`  in  1  synchronous, active-high reset.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1  Wishbone classic strobe, cycle and write enable. Strobe is already qualified by the top-level address decode.
- `wbs_sel_i`  in  4  ignored; all writes are full-word.
- `wbs_adr_i`  in  32  only `[3:2]` decoded.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  single-cycle acknowledge.
- `wbs_dat_o`  out  32  read data, valid with ack; 0 otherwise.
- `prog_clk_o`  out  1  configuration clock to fabric.
- `prog_reset_o`  out  1  configuration reset to fabric.
- `ccff_head_o`  out  1  serial configuration data.
- `ccff_tail_i`  in  1  chain output from fabric.
- `busy_o`  out  1  high while not IDLE.

## Operation
- **Registers:**
  - 0x0 CTRL:
    - [0] start: write-1, self-clearing.
    - [1] prog_reset: level; reset value 1.
    - [2] abort: write-1, self-clearing.
  - 0x4 LEN: total bits to shift, 32-bit.
  - 0x8 DATA:
    - Write pushes a word to the FIFO.
    - Read returns the readback shift register, i.e. the last 32 `ccff_tail` samples, newest in bit 0.
  - 0xC STATUS:
    - [0] busy.
    - [1] done: sticky, write-1-to-clear.
    - [2] fifo_empty.
    - [3] fifo_full.
    - [4] starved: sticky, write-1-to-clear.
    - [15:8] fifo level.
- **FSM states:** IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE.
  - IDLE→LOAD on start with LEN≠0. Start with LEN=0 sets done on the next cycle; no `prog_clk` pulses.
  - LOAD: pop a FIFO word into a 32-bit shift register and set bit index to 31, then go to SHIFT_LO. If the FIFO is empty, stay in LOAD with `prog_clk_o`=0, set starved, and resume when a word arrives.
  - SHIFT_LO:
    - Lasts CLK_DIV/2 cycles.
    - On entry, `ccff_head_o` takes the current MSB and `prog_clk_o`=0.
    - Then SHIFT_HI.
  - SHIFT_HI:
    - Lasts CLK_DIV/2 cycles with `prog_clk_o`=1.
    - `ccff_tail_i` is sampled in its first cycle and shifted into readback.
    - Remaining bits decrement at exit.
    - Exit goes to DONE when remaining=0, LOAD when bit index was 0, else SHIFT_LO.
  - DONE: one cycle; sets done; then IDLE. Untransmitted FIFO contents remain.
- **Partial final word:** if LEN mod 32≠0, only the top LEN mod 32 bits of the final word are shifted.
- **Abort:** in any state, the next cycle goes to IDLE, `prog_clk_o`=0 and the FIFO is flushed; done is not set. Abort wins over a simultaneous start.
- **Start while busy:** ignored. LEN writes while busy are ignored.
- **FIFO back-pressure:** a DATA write while the FIFO is full withholds ack until a pop frees space. A pop and a push in the same cycle are both honoured.

## Timing
- **Wishbone ack:** asserted the cycle after stb&cyc is first sampled; deasserted the next cycle. Exception: a full-FIFO DATA write, which acks the cycle after space exists.
- **Outputs:** all registered; no combinational path from input to output.
- **Bit period:** exactly CLK_DIV cycles per bit when the FIFO is not starved. A LOAD adds 1 cycle between words.
- **Start latency:** `prog_clk_o` first rises 1 (IDLE→LOAD) + 1 (LOAD) + CLK_DIV/2 cycles after the start write is acked.
- **Reset values:** `wbs_ack_o`=0, `wbs_dat_o`=0, `prog_clk_o`=0, `ccff_head_o`=0, `prog_reset_o`=1, `busy_o`=0.
- **Register and FIFO reset state:** LEN=0, readback=0, sticky bits 0, FIFO empty.
- **Reset mid-operation:** same as above; no partial `prog_clk` pulse.

## Structure
- Package `ccff_loader_pkg`: register offsets, CTRL/STATUS bit positions, FSM state enum.
- Sub-module `ccff_word_fifo`: synchronous 32-bit FIFO with push, pop, flush, full, empty and level outputs.

## Test plan
- **Reset check:** reset, read STATUS → 0x0000_0004; `prog_reset_o`=1, `prog_clk_o`=0.
- **Partial word:** LEN=8, DATA=0xA500_0000, start, CLK_DIV=4.
  - Expect 8 `prog_clk` pulses, each high for 2 cycles.
  - Expect `ccff_head` sequence 1,0,1,0,0,1,0,1.
  - Done=1; FIFO empty.
- **Loopback:** tie `ccff_tail_i`=`ccff_head_o`, LEN=32, DATA=0x1234_5678, start → DATA readback 0x1234_5678.
- **Back-pressure:** FIFO_DEPTH=4, five DATA writes while idle → fifth ack withheld until start pops the first word; level reads 4.
- **Starve and resume:** LEN=64 with one word queued → after 32 bits `prog_clk` is held low and starved=1; a second write resumes it; done after 64 pulses.
- **Abort:** abort during bit 10 of 32 → `prog_clk_o`=0 next cycle, busy=0, done=0, FIFO level 0.
